e_mdu: RTL and testbench
========================

# e_mdu

Execute-stage multiply/divide unit for the pipelined MIPS core: owns the HI/LO registers, runs multi-cycle MULT/MULTU/DIV/DIVU, and drives the `busy` status that the hazard logic turns into the `stall` bubble fed into the D→E pipeline register. It sits beside the E-stage ALU. It consumes the forwarded rs/rt operands and the exception `req` flush. Its HI/LO values are read by MFHI/MFLO in the same stage.

## Interface
- `MULT_CYCLES`, default 5, busy cycles for MULT/MULTU (and MADD/MADDU), ≥1
- `DIV_CYCLES`, default 10, busy cycles for DIV/DIVU, ≥1
- `clk`, in, 1, clock
- `reset`, in, 1, reset, synchronous, active-high
- `start`, in, 1, E-stage instruction is an MDU write op this cycle
- `op`, in, 4, 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9–15 NONE
- `rs_val`, in, 32, forwarded rs operand
- `rt_val`, in, 32, forwarded rt operand
- `req`, in, 1, exception/interrupt flush of the E-stage instruction
- `busy`, out, 1, multi-cycle op in progress
- `hi`, out, 32, architectural HI
- `lo`, out, 32, architectural LO

## Operation
- Accepted start: `start && !req && !busy && op != NONE`. Any other start is ignored with no state change. The hazard unit guarantees that no start arrives while `busy` is high.
- MULT: signed 32×32→64. MULTU: unsigned. Computed at the accept edge into pending regs `{p_hi,p_lo}`, with `p_hi` = upper 32 bits.
- DIV: signed. `p_lo` = quotient truncated toward zero, `p_hi` = remainder with the sign of the dividend. DIVU: unsigned.
- Divide by zero (`rt_val == 0`): the op is accepted and busy runs the full `DIV_CYCLES`, but HI/LO are left unchanged at completion.
- Multiply/divide accept loads `cnt` with `MULT_CYCLES` or `DIV_CYCLES`. Each edge with `cnt != 0` decrements it. The edge where `cnt == 1` writes `{p_hi,p_lo}` to HI/LO.
- `busy = (cnt != 0)`, registered-state derived.
- MTHI/MTLO: write `rs_val` to HI/LO at the accept edge. No busy.
- `req` arriving while `busy` does not abort the running op, because that instruction has already passed E. It completes and commits normally.
- `hi`/`lo` are driven directly from the HI/LO registers. There is no bypass of a pending result.

## Timing
- Reset: `hi=0`, `lo=0`, `busy=0`, `cnt=0`, pending regs 0. Reset mid-operation aborts it, and nothing is written.
- Multi-cycle op accepted in cycle t:
  - `busy` is 1 in cycles t+1 … t+N, where N is `MULT_CYCLES` or `DIV_CYCLES`.
  - HI/LO are updated at the edge closing cycle t+N and are visible in cycle t+N+1, when `busy=0`.
  - A new start is legal in cycle t+N+1.
- MTHI/MTLO accepted in cycle t: the new value is visible on `hi`/`lo` in cycle t+1.
- `busy` never asserts in the accept cycle itself. The hazard unit combines `start` with `busy` for the stall decision.
- Back-to-back: a start in cycle t+N+1 is accepted even though HI/LO changed on the preceding edge. Operands come from `rs_val`/`rt_val`, not from HI/LO, except for MADD accumulation, which uses the committed HI/LO.

## Configuration
- `MDU_MADD_EN` defined:
  - op 7 MADD computes `{HI,LO} + signed(rs)*signed(rt)` into the pending regs at accept, using the HI/LO committed at that edge. Wrap is mod 2^64.
  - op 8 MADDU does the same unsigned.
  - Both use `MULT_CYCLES`.
- `MDU_MADD_EN` undefined: ops 7 and 8 decode as NONE. They are never accepted, `busy` stays 0, and HI/LO are unchanged.

## Test plan
- **Reset and signed MULT:** reset, then MULT `rs=0xFFFFFFFE`, `rt=3` → `busy` high exactly 5 cycles, then `hi=0xFFFFFFFF`, `lo=0xFFFFFFFA`.
- **DIV and DIVU:**
  - DIV `rs=0xFFFFFFF9` (−7), `rt=2` → `busy` 10 cycles, then `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
  - DIVU on the same operands → `lo=0x7FFFFFFC`, `hi=1`.
- **Divide by zero:** MTHI `0x1234` and MTLO `0x5678` (each visible the next cycle), then DIV with `rt=0` → `busy` 10 cycles, HI/LO remain `0x1234`/`0x5678`.
- **Flush interactions:**
  - `start`+MULT with `req=1` → `busy` stays 0 and HI/LO are unchanged.
  - `req` pulsed in cycle t+2 of a running MULTU `0xFFFFFFFF*2` → completes with `hi=1`, `lo=0xFFFFFFFE`.
- **Reset mid-DIV:** assert `reset` in cycle t+4 → next cycle `busy=0` and `hi=lo=0`. A later DIVU 100/7 gives `lo=14`, `hi=2`.
- **MADD (with `MDU_MADD_EN`):** HI=0, LO=`0xFFFFFFFF`, then MADDU `rs=1`, `rt=1` → after 5 cycles `hi=1`, `lo=0`. Without the macro, the same stimulus leaves HI/LO unchanged and `busy=0`.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with architectural HI/LO.
// Multiply and divide results are computed at the accept edge and held in
// pending registers. They are committed to HI/LO after a fixed busy window.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU accumulation.
// Without that macro, ops 7 and 8 decode as NONE.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    // Set when the running op is a divide by zero: commit is suppressed.
    logic          dz_q, dz_d;

    logic is_mul, is_div, is_mthi, is_mtlo, is_madd, sgn, op_valid, accept;

    logic [32:0]        a_ext, b_ext;
    logic signed [65:0] prod;
    logic [63:0]        mul_res;

    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs, div_b, uq, ur, quo, rem;

    assign busy = (cnt_q != '0);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Decode op into operation class and signedness.
    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_mthi = 1'b0;
        is_mtlo = 1'b0;
        is_madd = 1'b0;
        sgn     = 1'b0;
        case (op)
            OP_MULT:  begin is_mul = 1'b1; sgn = 1'b1; end
            OP_MULTU: begin is_mul = 1'b1; end
            OP_DIV:   begin is_div = 1'b1; sgn = 1'b1; end
            OP_DIVU:  begin is_div = 1'b1; end
            OP_MTHI:  begin is_mthi = 1'b1; end
            OP_MTLO:  begin is_mtlo = 1'b1; end
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; is_madd = 1'b1; sgn = 1'b1; end
            OP_MADDU: begin is_mul = 1'b1; is_madd = 1'b1; end
`endif
            default:  begin end
        endcase
        op_valid = is_mul | is_div | is_mthi | is_mtlo;
        accept   = start && !req && !busy && op_valid;
    end

    // Multiplier: 33-bit extension gives one signed multiply for both
    // signed and unsigned forms. The accumulate term adds the committed HI/LO.
    always_comb begin
        a_ext   = {sgn & rs_val[31], rs_val};
        b_ext   = {sgn & rt_val[31], rt_val};
        prod    = $signed(a_ext) * $signed(b_ext);
        mul_res = prod[63:0] + (is_madd ? {hi_q, lo_q} : 64'd0);
    end

    // Divider on magnitudes with sign fix-up. A zero divisor is replaced by
    // one, which keeps the arithmetic defined. That result is never committed.
    always_comb begin
        a_neg = sgn & rs_val[31];
        b_neg = sgn & rt_val[31];
        a_abs = a_neg ? (32'd0 - rs_val) : rs_val;
        b_abs = b_neg ? (32'd0 - rt_val) : rt_val;
        div_b = (b_abs == 32'd0) ? 32'd1 : b_abs;
        uq    = a_abs / div_b;
        ur    = a_abs % div_b;
        quo   = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem   = a_neg ? (32'd0 - ur) : ur;
    end

    // Next-state: accept loads pending regs and counter. The counter's last
    // step commits the pending result.
    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        p_hi_d = p_hi_q;
        p_lo_d = p_lo_q;
        dz_d   = dz_q;
        if (accept) begin
            if (is_mul) begin
                {p_hi_d, p_lo_d} = mul_res;
                cnt_d            = MULT_LOAD;
                dz_d             = 1'b0;
            end
            if (is_div) begin
                p_hi_d = rem;
                p_lo_d = quo;
                cnt_d  = DIV_LOAD;
                dz_d   = (rt_val == 32'd0);
            end
            if (is_mthi) hi_d = rs_val;
            if (is_mtlo) lo_d = rs_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE && !dz_q) begin
                hi_d = p_hi_q;
                lo_d = p_lo_q;
            end
        end
    end

    // State registers. Reset clears everything and aborts any running op.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            p_hi_q <= 32'd0;
            p_lo_q <= 32'd0;
            dz_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            p_hi_q <= p_hi_d;
            p_lo_q <= p_lo_d;
            dz_q   <= dz_d;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed bench for e_mdu. The stimulus pushes the expected
// busy length and HI/LO into a queue. A monitor pops the queue when busy
// falls, or on a probe strobe for single-cycle or ignored ops, and compares.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        probe;

    typedef struct {
        string       name;
        int          run;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .req    (req),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input string what,
                         input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s.%s got=0x%08h want=0x%08h", name, what, got, exp);
        end
    endtask

    // Monitor: compares one queued expectation per observed transaction.
    initial begin
        int   run;
        logic prev_busy;
        exp_t e;
        run       = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (probe) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL probe: no expectation queued");
                end else begin
                    e = sb.pop_front();
                    check(e.name, "busy", {31'd0, busy}, 32'd0);
                    check(e.name, "hi", hi, e.hi);
                    check(e.name, "lo", lo, e.lo);
                    $display("txn %s: busy=%0b hi=0x%08h lo=0x%08h", e.name, busy, hi, lo);
                end
            end else if (busy) begin
                run++;
            end else begin
                if (prev_busy) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL busy_end: unexpected completion run=%0d", run);
                    end else begin
                        e = sb.pop_front();
                        check(e.name, "busy_cycles", run, e.run);
                        check(e.name, "hi", hi, e.hi);
                        check(e.name, "lo", lo, e.lo);
                        $display("txn %s: busy_cycles=%0d hi=0x%08h lo=0x%08h", e.name, run, hi, lo);
                    end
                end
                run = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic push(input string name, input int run,
                        input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.name = name; e.run = run; e.hi = h; e.lo = l;
        sb.push_back(e);
    endtask

    // Drive start for exactly one cycle; returns 1 time unit into the next cycle.
    task automatic start_op(input logic [3:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic rq);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_val = a; rt_val = b; req = rq;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0; req = 1'b0;
    endtask

    task automatic pulse_probe();
        probe = 1'b1;
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k;
        k = 0;
        while (sb.size() != 0 && k < bound) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL %s.timeout pending=%0d after %0d cycles", name, sb.size(), bound);
            sb.delete();
        end
    endtask

    task automatic single(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic rq,
                          input logic [31:0] h, input logic [31:0] l);
        push(name, 0, h, l);
        start_op(o, a, b, rq);
        pulse_probe();
        wait_idle(name, 4);
    endtask

    task automatic multi(input string name, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] h, input logic [31:0] l);
        push(name, n, h, l);
        start_op(o, a, b, 1'b0);
        wait_idle(name, n + 6);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
        req = 1'b0; probe = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        push("reset", 0, 32'd0, 32'd0);
        pulse_probe();
        wait_idle("reset", 4);

        multi("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        multi("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        multi("divu", 4'd4, 32'hFFFF_FFF9, 32'd2, 10, 32'd1, 32'h7FFF_FFFC);

        single("mthi", 4'd5, 32'h1234, 32'd0, 1'b0, 32'h1234, 32'h7FFF_FFFC);
        single("mtlo", 4'd6, 32'h5678, 32'd0, 1'b0, 32'h1234, 32'h5678);
        multi("div_by_zero", 4'd3, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);

        // Starts that must be ignored.
        single("mult_flushed", 4'd1, 32'd6, 32'd7, 1'b1, 32'h1234, 32'h5678);
        single("op_none0", 4'd0, 32'hDEAD, 32'hBEEF, 1'b0, 32'h1234, 32'h5678);
        single("op_none12", 4'd12, 32'hDEAD, 32'hBEEF, 1'b0, 32'h1234, 32'h5678);

        // A req pulse during a running op does not abort it.
        push("multu_req_mid", 5, 32'd1, 32'hFFFF_FFFE);
        start_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        @(posedge clk); #1;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        wait_idle("multu_req_mid", 10);

        // Reset in cycle t+4 of a DIV: busy ran 4 cycles and HI/LO are cleared.
        push("div_reset_mid", 4, 32'd0, 32'd0);
        start_op(4'd3, 32'd1000, 32'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wait_idle("div_reset_mid", 10);

        // Back-to-back: the DIVU starts in cycle t+N+1 of the MULT.
        push("mult_b2b", 5, 32'd0, 32'd42);
        push("divu_b2b", 10, 32'd2, 32'd14);
        start_op(4'd1, 32'd6, 32'd7, 1'b0);
        repeat (4) @(posedge clk);
        start_op(4'd4, 32'd100, 32'd7, 1'b0);
        wait_idle("b2b", 24);

        // Accumulate ops.
        single("mthi_0", 4'd5, 32'd0, 32'd0, 1'b0, 32'd0, 32'd14);
        single("mtlo_ff", 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        multi("maddu", 4'd8, 32'd1, 32'd1, 5, 32'd1, 32'd0);
        multi("madd_neg", 4'd7, 32'hFFFF_FFFF, 32'd1, 5, 32'd0, 32'hFFFF_FFFF);
`else
        single("maddu_off", 4'd8, 32'd1, 32'd1, 1'b0, 32'd0, 32'hFFFF_FFFF);
        single("madd_off", 4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'hFFFF_FFFF);
`endif

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover expectations=%0d", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
